// File: rtl/id_stage_ctrl_pkg.sv
// id_stage_ctrl_pkg: RV32I opcodes, func3 codes and control-bundle encodings shared by the decode stage.
package id_stage_ctrl_pkg;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;
  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam int F7_ALT_BIT = 30;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_A, ALU_B
  } alu_sel_e;
  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_CSR} imm_sel_e;
  typedef enum logic [2:0] {WB_ALU, WB_MEM, WB_PC4, WB_CSR} wb_sel_e;
  typedef enum logic {A_RS1, A_PC} a_sel_e;
  typedef enum logic {B_RS2, B_IMM} b_sel_e;
  typedef enum logic [1:0] {PC_PLUS4, PC_BRANCH, PC_JUMP} pc_sel_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} dmem_size_e;
  typedef enum logic {RUN, STALL} state_e;
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rf_wen;
    imm_sel_e   imm_sel;
    a_sel_e     a_sel;
    b_sel_e     b_sel;
    alu_sel_e   alu_sel;
    logic       br_en;
    logic [2:0] br_func;
    logic       jump;
    logic       dmem_wen;
    logic       dmem_ren;
    logic       dmem_unsign;
    dmem_size_e dmem_size;
    wb_sel_e    wb_sel;
    logic       csr_wen;
    logic       illegal;
  } ctrl_t;
  // SUB only exists in the register form; the immediate form keeps inst[30] as immediate data
  function automatic alu_sel_e alu_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    case (f3)
      F3_ADDSUB: alu_op = (alt & is_reg) ? ALU_SUB : ALU_ADD;
      F3_SLL:    alu_op = ALU_SLL;
      F3_SLT:    alu_op = ALU_SLT;
      F3_SLTU:   alu_op = ALU_SLTU;
      F3_XOR:    alu_op = ALU_XOR;
      F3_SR:     alu_op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:     alu_op = ALU_OR;
      F3_AND:    alu_op = ALU_AND;
      default:   alu_op = ALU_ADD;
    endcase
  endfunction
endpackage

// File: rtl/id_stage_ctrl_decode.sv
// id_decode: combinational RV32I instruction -> control bundle, illegal flag and source-register usage.
// ID_CSR_EN enables CSRRW/CSRRWI decode on the SYSTEM opcode; otherwise SYSTEM is illegal.
module id_decode
  import id_stage_ctrl_pkg::*;
(
  input  logic [31:0] inst_i,
  output ctrl_t       ctrl_o,
  output logic        uses_rs1_o,
  output logic        uses_rs2_o
);
  logic [6:0] op;
  logic [2:0] f3;
  logic       alt;
  logic       ill;
  logic       unused_bits;
  assign op          = inst_i[6:0];
  assign f3          = inst_i[14:12];
  assign alt         = inst_i[F7_ALT_BIT];
  assign unused_bits = ^{inst_i[31], inst_i[29:25]};
  always_comb begin
    ctrl_o         = '0;
    ctrl_o.rd      = inst_i[11:7];
    ctrl_o.rs1     = inst_i[19:15];
    ctrl_o.rs2     = inst_i[24:20];
    ctrl_o.a_sel   = A_PC;
    ctrl_o.b_sel   = B_IMM;
    ctrl_o.alu_sel = ALU_ADD;
    uses_rs1_o     = 1'b0;
    uses_rs2_o     = 1'b0;
    ill            = 1'b0;
    case (op)
      OP_LUI: begin
        ctrl_o.imm_sel = IMM_U;
        ctrl_o.alu_sel = ALU_B;
        ctrl_o.rf_wen  = 1'b1;
      end
      OP_AUIPC: begin
        ctrl_o.imm_sel = IMM_U;
        ctrl_o.rf_wen  = 1'b1;
      end
      OP_JAL: begin
        ctrl_o.imm_sel = IMM_J;
        ctrl_o.jump    = 1'b1;
        ctrl_o.rf_wen  = 1'b1;
        ctrl_o.wb_sel  = WB_PC4;
      end
      OP_JALR: begin
        ctrl_o.a_sel  = A_RS1;
        ctrl_o.jump   = 1'b1;
        ctrl_o.rf_wen = 1'b1;
        ctrl_o.wb_sel = WB_PC4;
        uses_rs1_o    = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_o.imm_sel = IMM_B;
        ctrl_o.br_en   = 1'b1;
        ctrl_o.br_func = f3;
        uses_rs1_o     = 1'b1;
        uses_rs2_o     = 1'b1;
        ill            = f3[2:1] == 2'b01;
      end
      OP_LOAD: begin
        ctrl_o.a_sel       = A_RS1;
        ctrl_o.rf_wen      = 1'b1;
        ctrl_o.dmem_ren    = 1'b1;
        ctrl_o.dmem_size   = dmem_size_e'(f3[1:0]);
        ctrl_o.dmem_unsign = f3[2];
        ctrl_o.wb_sel      = WB_MEM;
        uses_rs1_o         = 1'b1;
        ill                = f3 == 3'b011 || f3[2:1] == 2'b11;
      end
      OP_STORE: begin
        ctrl_o.imm_sel   = IMM_S;
        ctrl_o.a_sel     = A_RS1;
        ctrl_o.dmem_wen  = 1'b1;
        ctrl_o.dmem_size = dmem_size_e'(f3[1:0]);
        uses_rs1_o       = 1'b1;
        uses_rs2_o       = 1'b1;
        ill              = f3 > 3'd2;
      end
      OP_REG: begin
        ctrl_o.a_sel   = A_RS1;
        ctrl_o.b_sel   = B_RS2;
        ctrl_o.alu_sel = alu_op(f3, alt, 1'b1);
        ctrl_o.rf_wen  = 1'b1;
        uses_rs1_o     = 1'b1;
        uses_rs2_o     = 1'b1;
      end
      OP_IMM: begin
        ctrl_o.a_sel   = A_RS1;
        ctrl_o.alu_sel = alu_op(f3, alt, 1'b0);
        ctrl_o.rf_wen  = 1'b1;
        uses_rs1_o     = 1'b1;
      end
`ifdef ID_CSR_EN
      OP_SYSTEM: begin
        ctrl_o.csr_wen = 1'b1;
        ctrl_o.rf_wen  = 1'b1;
        ctrl_o.wb_sel  = WB_CSR;
        if (f3 == F3_CSRRW) begin
          ctrl_o.a_sel   = A_RS1;
          ctrl_o.alu_sel = ALU_A;
          uses_rs1_o     = 1'b1;
        end else if (f3 == F3_CSRRWI) begin
          ctrl_o.imm_sel = IMM_CSR;
          ctrl_o.alu_sel = ALU_B;
        end else begin
          ill = 1'b1;
        end
      end
`endif
      default: ill = 1'b1;
    endcase
    ill = ill | (inst_i[1:0] != 2'b11);
    if (ill) begin
      ctrl_o.rf_wen   = 1'b0;
      ctrl_o.dmem_wen = 1'b0;
      ctrl_o.dmem_ren = 1'b0;
      ctrl_o.csr_wen  = 1'b0;
      ctrl_o.br_en    = 1'b0;
      ctrl_o.jump     = 1'b0;
    end
    ctrl_o.illegal = ill;
  end
endmodule

// File: rtl/id_stage_ctrl.sv
// id_stage_ctrl: registered RV32I decode stage with load-use bubbles and EX flush.
// ID_CSR_EN (passed through to id_decode) enables CSRRW/CSRRWI decode.
module id_stage_ctrl
  import id_stage_ctrl_pkg::*;
#(
  parameter int XLEN            = 32,
  parameter int IMEM_DWIDTH     = 32,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   if_valid,
  output logic                   if_ready,
  input  logic [IMEM_DWIDTH-1:0] if_inst,
  input  logic [XLEN-1:0]        if_pc,
  input  logic                   flush,
  input  logic                   ex_ready,
  output logic                   ex_valid,
  output logic [XLEN-1:0]        ex_pc,
  output logic [4:0]             ex_rd,
  output logic [4:0]             ex_rs1,
  output logic [4:0]             ex_rs2,
  output logic                   ex_rf_wen,
  output logic [2:0]             ex_imm_sel,
  output logic                   ex_alu_a_sel,
  output logic                   ex_alu_b_sel,
  output logic [3:0]             ex_alu_sel,
  output logic                   ex_br_en,
  output logic [2:0]             ex_br_func,
  output logic                   ex_jump,
  output logic                   ex_dmem_wen,
  output logic                   ex_dmem_ren,
  output logic                   ex_dmem_unsign,
  output logic [1:0]             ex_dmem_size,
  output logic [2:0]             ex_wb_sel,
  output logic                   ex_csr_wen,
  output logic                   ex_illegal
);
  localparam logic [1:0] STALL_INIT = 2'(LOAD_USE_STALLS - 1);
  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  ctrl_t           ctrl_q, ctrl_d, dec;
  logic            uses_rs1, uses_rs2, ld, haz;
  id_decode u_dec (
    .inst_i     (if_inst),
    .ctrl_o     (dec),
    .uses_rs1_o (uses_rs1),
    .uses_rs2_o (uses_rs2)
  );
  assign ld  = !valid_q | ex_ready;
  assign haz = valid_q & ctrl_q.dmem_ren & (ctrl_q.rd != 5'd0) &
               ((uses_rs1 & (dec.rs1 == ctrl_q.rd)) | (uses_rs2 & (dec.rs2 == ctrl_q.rd)));
  assign if_ready = flush | (ld & (state_q == RUN) & !haz);
  // flush outranks everything; a bubble is an all-zero register with valid low
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      state_d = RUN;
      cnt_d   = 2'd0;
      valid_d = 1'b0;
      pc_d    = '0;
      ctrl_d  = '0;
    end else if (ld) begin
      valid_d = (state_q == RUN) & !haz & if_valid;
      pc_d    = valid_d ? if_pc : '0;
      ctrl_d  = valid_d ? dec : '0;
      if (state_q == STALL) begin
        cnt_d   = cnt_q - 2'd1;
        state_d = (cnt_q == 2'd1) ? RUN : STALL;
      end else if (haz) begin
        cnt_d   = STALL_INIT;
        state_d = (STALL_INIT != 2'd0) ? STALL : RUN;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      ctrl_q  <= ctrl_d;
    end
  end
  assign ex_valid       = valid_q;
  assign ex_pc          = pc_q;
  assign ex_rd          = ctrl_q.rd;
  assign ex_rs1         = ctrl_q.rs1;
  assign ex_rs2         = ctrl_q.rs2;
  assign ex_rf_wen      = ctrl_q.rf_wen;
  assign ex_imm_sel     = ctrl_q.imm_sel;
  assign ex_alu_a_sel   = ctrl_q.a_sel;
  assign ex_alu_b_sel   = ctrl_q.b_sel;
  assign ex_alu_sel     = ctrl_q.alu_sel;
  assign ex_br_en       = ctrl_q.br_en;
  assign ex_br_func     = ctrl_q.br_func;
  assign ex_jump        = ctrl_q.jump;
  assign ex_dmem_wen    = ctrl_q.dmem_wen;
  assign ex_dmem_ren    = ctrl_q.dmem_ren;
  assign ex_dmem_unsign = ctrl_q.dmem_unsign;
  assign ex_dmem_size   = ctrl_q.dmem_size;
  assign ex_wb_sel      = ctrl_q.wb_sel;
  assign ex_csr_wen     = ctrl_q.csr_wen;
  assign ex_illegal     = ctrl_q.illegal;
endmodule

// File: tb/tb_id_stage_ctrl.sv
// tb_id_stage_ctrl: scoreboard bench for id_stage_ctrl with two load-use bubbles.
module tb_id_stage_ctrl;
  import id_stage_ctrl_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [3:0]  alu;
    logic [2:0]  wb;
    logic [2:0]  imm;
    logic [1:0]  ab;
    logic [1:0]  sz;
    logic        uns;
    logic [6:0]  en;
  } exp_t;
  localparam logic [6:0] E_RF = 7'h40, E_WM = 7'h20, E_RM = 7'h10, E_CSR = 7'h08;
  localparam logic [6:0] E_BR = 7'h04, E_J = 7'h02, E_ILL = 7'h01;
  logic        clk = 1'b0, rst = 1'b1;
  logic        if_valid = 1'b0, flush = 1'b0, ex_ready = 1'b1;
  logic [31:0] if_inst = '0, if_pc = '0;
  logic        if_ready, ex_valid, ex_rf_wen, ex_alu_a_sel, ex_alu_b_sel, ex_br_en, ex_jump;
  logic        ex_dmem_wen, ex_dmem_ren, ex_dmem_unsign, ex_csr_wen, ex_illegal;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic [2:0]  ex_imm_sel, ex_br_func, ex_wb_sel;
  logic [3:0]  ex_alu_sel;
  logic [1:0]  ex_dmem_size;
  int          n_chk = 0, n_err = 0;
  exp_t        sb[$];
  exp_t        cur_exp, mon_e;
  logic [31:0] pc_n = 32'h1000, last_pc;
  id_stage_ctrl #(.LOAD_USE_STALLS(2)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_inst(if_inst),
    .if_pc(if_pc), .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rf_wen(ex_rf_wen),
    .ex_imm_sel(ex_imm_sel), .ex_alu_a_sel(ex_alu_a_sel), .ex_alu_b_sel(ex_alu_b_sel),
    .ex_alu_sel(ex_alu_sel), .ex_br_en(ex_br_en), .ex_br_func(ex_br_func), .ex_jump(ex_jump),
    .ex_dmem_wen(ex_dmem_wen), .ex_dmem_ren(ex_dmem_ren), .ex_dmem_unsign(ex_dmem_unsign),
    .ex_dmem_size(ex_dmem_size), .ex_wb_sel(ex_wb_sel), .ex_csr_wen(ex_csr_wen),
    .ex_illegal(ex_illegal)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic exp_t mk(input logic [4:0] rd, input logic [3:0] alu, input logic [2:0] wb,
                              input logic [2:0] imm, input logic [1:0] ab, input logic [1:0] sz,
                              input logic uns, input logic [6:0] en);
    exp_t e;
    e = '{pc: 32'h0, rd: rd, alu: alu, wb: wb, imm: imm, ab: ab, sz: sz, uns: uns, en: en};
    return e;
  endfunction
  task automatic drive(input logic [31:0] inst, input exp_t e);
    if_valid   = 1'b1;
    if_inst    = inst;
    if_pc      = pc_n;
    last_pc    = pc_n;
    cur_exp    = e;
    cur_exp.pc = pc_n;
    pc_n       = pc_n + 32'd4;
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [31:0] inst, input exp_t e, output int w);
    logic acc;
    drive(inst, e);
    w   = 0;
    acc = 1'b0;
    while (!acc && w < 20) begin
      @(negedge clk);
      acc = if_ready;
      step();
      if (!acc) w++;
    end
    chk("handshake", acc, 1);
    if_valid = 1'b0;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (ex_valid && (ex_ready || flush)) begin
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          if (ex_ready) begin
            chk("pc", ex_pc, mon_e.pc);
            chk("rd", ex_rd, mon_e.rd);
            chk("alu", ex_alu_sel, mon_e.alu);
            chk("wb", ex_wb_sel, mon_e.wb);
            chk("imm", ex_imm_sel, mon_e.imm);
            chk("ab", {ex_alu_a_sel, ex_alu_b_sel}, mon_e.ab);
            chk("size", {ex_dmem_size, ex_dmem_unsign}, {mon_e.sz, mon_e.uns});
            chk("en", {ex_rf_wen, ex_dmem_wen, ex_dmem_ren, ex_csr_wen, ex_br_en, ex_jump, ex_illegal},
                mon_e.en);
          end
        end
      end
      if (if_valid && if_ready && !flush) sb.push_back(cur_exp);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int w;
    exp_t add6;
    add6 = mk(6, ALU_ADD, WB_ALU, IMM_I, 2'b00, SZ_B, 0, E_RF);
    repeat (2) step();
    chk("rst_valid", ex_valid, 0);
    chk("rst_outs", |{ex_pc, ex_rd, ex_rs1, ex_rs2, ex_rf_wen, ex_imm_sel, ex_alu_sel, ex_wb_sel}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", if_ready, 1);
    step();
    // decode patterns, back-to-back with EX always ready
    put(32'h003100B3, mk(1, ALU_ADD, WB_ALU, IMM_I, 2'b00, SZ_B, 0, E_RF), w);
    put(32'h40508233, mk(4, ALU_SUB, WB_ALU, IMM_I, 2'b00, SZ_B, 0, E_RF), w);
    chk("b2b_wait", w, 0);
    @(negedge clk);
    chk("b2b_valid", ex_valid, 1);
    step();
    put(32'h123451B7, mk(3, ALU_B, WB_ALU, IMM_U, 2'b11, SZ_B, 0, E_RF), w);
    put(32'h40345393, mk(7, ALU_SRA, WB_ALU, IMM_I, 2'b01, SZ_B, 0, E_RF), w);
    put(32'hFFF08093, mk(1, ALU_ADD, WB_ALU, IMM_I, 2'b01, SZ_B, 0, E_RF), w);
    put(32'h008000EF, mk(1, ALU_ADD, WB_PC4, IMM_J, 2'b11, SZ_B, 0, E_RF | E_J), w);
    put(32'h0020A223, mk(4, ALU_ADD, WB_ALU, IMM_S, 2'b01, SZ_W, 0, E_WM), w);
    put(32'h0000C483, mk(9, ALU_ADD, WB_MEM, IMM_I, 2'b01, SZ_B, 1, E_RF | E_RM), w);
    put(32'h00209063, mk(0, ALU_ADD, WB_ALU, IMM_B, 2'b11, SZ_B, 0, E_BR), w);
    put(32'h0000007F, mk(0, ALU_ADD, WB_ALU, IMM_I, 2'b11, SZ_B, 0, E_ILL), w);
    put(32'h0020A063, mk(0, ALU_ADD, WB_ALU, IMM_B, 2'b11, SZ_B, 0, E_ILL), w);
`ifdef ID_CSR_EN
    put(32'h300110F3, mk(1, ALU_A, WB_CSR, IMM_I, 2'b01, SZ_B, 0, E_RF | E_CSR), w);
`else
    put(32'h300110F3, mk(1, ALU_ADD, WB_ALU, IMM_I, 2'b11, SZ_B, 0, E_ILL), w);
`endif
    // load-use: LW x5 then ADD x6,x5,x7 -> two bubbles
    put(32'h0000A283, mk(5, ALU_ADD, WB_MEM, IMM_I, 2'b01, SZ_W, 0, E_RF | E_RM), w);
    drive(32'h00728333, add6);
    @(negedge clk);
    chk("lu_rdy0", if_ready, 0);
    chk("lu_ev0", ex_valid, 1);
    step();
    @(negedge clk);
    chk("lu_rdy1", if_ready, 0);
    chk("lu_ev1", ex_valid, 0);
    step();
    @(negedge clk);
    chk("lu_rdy2", if_ready, 1);
    chk("lu_ev2", ex_valid, 0);
    step();
    if_valid = 1'b0;
    @(negedge clk);
    chk("lu_issue", ex_valid, 1);
    step();
    // load to x0 never stalls
    put(32'h0000A003, mk(0, ALU_ADD, WB_MEM, IMM_I, 2'b01, SZ_W, 0, E_RF | E_RM), w);
    put(32'h00700333, add6, w);
    chk("x0_nostall", w, 0);
    // EX back-pressure holds the register
    put(32'h123451B7, mk(3, ALU_B, WB_ALU, IMM_U, 2'b11, SZ_B, 0, E_RF), w);
    ex_ready = 1'b0;
    drive(32'h40345393, mk(7, ALU_SRA, WB_ALU, IMM_I, 2'b01, SZ_B, 0, E_RF));
    pc_n = pc_n - 32'd4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ev", ex_valid, 1);
      chk("hold_rdy", if_ready, 0);
      chk("hold_pc", ex_pc, last_pc - 32'd4);
      chk("hold_alu", ex_alu_sel, ALU_B);
      step();
    end
    ex_ready = 1'b1;
    put(32'h40345393, mk(7, ALU_SRA, WB_ALU, IMM_I, 2'b01, SZ_B, 0, E_RF), w);
    chk("hold_release", w, 0);
    // flush while stalled drops the held instruction
    put(32'h0000A283, mk(5, ALU_ADD, WB_MEM, IMM_I, 2'b01, SZ_W, 0, E_RF | E_RM), w);
    drive(32'h00728333, add6);
    @(negedge clk);
    chk("fl_haz", if_ready, 0);
    step();
    flush = 1'b1;
    @(negedge clk);
    chk("fl_rdy", if_ready, 1);
    step();
    flush    = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    chk("fl_ev", ex_valid, 0);
    chk("fl_run", if_ready, 1);
    step();
    put(32'h00728333, add6, w);
    chk("fl_run_w", w, 0);
    // flush with EX not ready still clears the register
    put(32'h008000EF, mk(1, ALU_ADD, WB_PC4, IMM_J, 2'b11, SZ_B, 0, E_RF | E_J), w);
    ex_ready = 1'b0;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("fl_clr", ex_valid, 0);
    step();
    // asynchronous reset while the register is live
    put(32'h00209063, mk(0, ALU_ADD, WB_ALU, IMM_B, 2'b11, SZ_B, 0, E_BR), w);
    ex_ready = 1'b0;
    @(negedge clk);
    chk("mid_ev", ex_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_outs", |{ex_valid, ex_pc, ex_rd, ex_rs1, ex_rs2, ex_rf_wen, ex_imm_sel,
                          ex_alu_a_sel, ex_alu_b_sel, ex_alu_sel, ex_br_en, ex_br_func, ex_jump,
                          ex_dmem_wen, ex_dmem_ren, ex_dmem_unsign, ex_dmem_size, ex_wb_sel,
                          ex_csr_wen, ex_illegal}, 0);
    sb.delete();
    step();
    rst      = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("mid_rdy", if_ready, 1);
    chk("mid_ev0", ex_valid, 0);
    repeat (3) step();
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
